gate_sweep_tester: RTL and testbench

- Self-checking, on-board exhaustive tester for one N-input combinational gate (the DUT).
- Replaces hand-wired per-vector LED checks with a sequenced sweep over all 2^WIDTH input vectors.
- Compares each DUT output to a golden value selected by MODE and latches pass/fail onto board LEDs.
- Sits between the board clock/LED top level and any single-output gate module.

---
 rtl/gate_test_pkg.sv | 35 +++
 rtl/led_blinker.sv | 32 +++
 rtl/gate_sweep_tester.sv | 114 +++++++++++
 tb/tb_gate_sweep_tester.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// Shared definitions for the board-level *_sweep gate testers:
// mode encodings, FSM state codes and the golden gate function.
package gate_test_pkg;

    localparam logic [2:0] MODE_OR   = 3'd0;
    localparam logic [2:0] MODE_AND  = 3'd1;
    localparam logic [2:0] MODE_XOR  = 3'd2;
    localparam logic [2:0] MODE_NOR  = 3'd3;
    localparam logic [2:0] MODE_NAND = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_DRIVE  = 3'd1;
    localparam state_t ST_SETTLE = 3'd2;
    localparam state_t ST_CHECK  = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    // Bits of vector above width are ignored; AND pads them with ones.
    function automatic logic golden_fn(input logic [2:0] mode, input logic [7:0] vector,
                                       input int unsigned width);
        logic [7:0] mask;
        logic       r;
        mask = 8'((9'd1 << width) - 9'd1);
        case (mode)
            MODE_OR, MODE_NOR:   r = |(vector & mask);
            MODE_AND, MODE_NAND: r = &(vector | ~mask);
            default:             r = ^(vector & mask);
        endcase
        if (mode == MODE_NOR || mode == MODE_NAND || mode == MODE_XNOR)
            r = ~r;
        return r;
    endfunction

endpackage

// File: rtl/led_blinker.sv
// Square-wave LED driver: toggles every 2^BLINK_DIV clocks while en is high,
// held low (and the divider cleared) whenever en is low.
module led_blinker #(
    parameter int BLINK_DIV = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic led
);

    localparam logic [BLINK_DIV:0] WRAP = {1'b0, {BLINK_DIV{1'b1}}};

    logic [BLINK_DIV:0] cnt;
    logic               led_q;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt   <= '0;
            led_q <= 1'b0;
        end else if (cnt == WRAP) begin
            cnt   <= '0;
            led_q <= ~led_q;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Gate with en so the LED drops in the same cycle busy does.
    assign led = led_q & en;

endmodule

// File: rtl/gate_sweep_tester.sv
// Exhaustive on-board tester for a single-output combinational gate: sweeps all
// 2^WIDTH input vectors, compares against the golden gate and latches results to LEDs.
module gate_sweep_tester
    import gate_test_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int MODE          = 0,
    parameter int SETTLE_CYCLES = 4,
    parameter int AUTO_START    = 1,
    parameter int BLINK_DIV     = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] dut_in,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   fail_count,
    output logic [WIDTH-1:0] first_fail,
    output logic             led_pass,
    output logic             led_fail,
    output logic             led_busy
);

    localparam logic [WIDTH:0] LAST_VEC    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] FAIL_MAX    = '1;
    localparam logic [7:0]     SETTLE_INIT = 8'(SETTLE_CYCLES - 1);
    localparam bit             MODE_LEGAL  = (MODE >= 0) && (MODE <= 5);

    state_t         state;
    logic [WIDTH:0] vector;
    logic [7:0]     settle_cnt;
    logic           golden;
    logic           mismatch;

    // An illegal MODE makes every vector fail so the misconfiguration is visible on the board.
    always_comb begin
        golden   = MODE_LEGAL ? golden_fn(3'(MODE), 8'(vector[WIDTH-1:0]), WIDTH) : ~dut_out;
        mismatch = (dut_out != golden);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            vector     <= '0;
            settle_cnt <= '0;
            dut_in     <= '0;
            fail_count <= '0;
            first_fail <= '0;
            led_pass   <= 1'b0;
            led_fail   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start || (AUTO_START != 0)) begin
                        state      <= ST_DRIVE;
                        vector     <= '0;
                        fail_count <= '0;
                        first_fail <= '0;
                        led_fail   <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    dut_in     <= vector[WIDTH-1:0];
                    settle_cnt <= SETTLE_INIT;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0)
                        state <= ST_CHECK;
                    else
                        settle_cnt <= settle_cnt - 8'd1;
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (fail_count != FAIL_MAX)
                            fail_count <= fail_count + 1'b1;
                        led_fail <= 1'b1;
                        if (fail_count == '0)
                            first_fail <= vector[WIDTH-1:0];
                    end
                    if (vector == LAST_VEC) begin
                        state    <= ST_DONE;
                        led_pass <= !mismatch && (fail_count == '0);
                    end else begin
                        vector <= vector + 1'b1;
                        state  <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        state    <= ST_IDLE;
                        led_pass <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_CHECK);
    assign done = (state == ST_DONE);

    led_blinker #(
        .BLINK_DIV(BLINK_DIV)
    ) u_blink (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (busy),
        .led  (led_busy)
    );

endmodule

// File: tb/tb_gate_sweep_tester.sv
// Bench for gate_sweep_tester: four configurations, each driven by a table-based
// model gate; sweep results are predicted from gate truth rules by counting ones.
module tb_gate_sweep_tester;

    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]        rstn;
    logic [NI-1:0]        start;
    logic [NI-1:0]        dout;
    logic [NI-1:0]        busy, done, lpass, lfail, lbusy;
    logic [NI-1:0][7:0]   din;
    logic [NI-1:0][7:0]   ff;
    logic [NI-1:0][8:0]   fc;
    logic [NI-1:0][255:0] tt;

    logic [1:0] din0, ff0;  logic [2:0] fc0;
    logic [2:0] din1, ff1;  logic [3:0] fc1;
    logic [3:0] din2, ff2;  logic [4:0] fc2;
    logic [7:0] din3, ff3;  logic [8:0] fc3;

    int total = 0;
    int bad   = 0;

    assign din[0] = 8'(din0);  assign ff[0] = 8'(ff0);  assign fc[0] = 9'(fc0);
    assign din[1] = 8'(din1);  assign ff[1] = 8'(ff1);  assign fc[1] = 9'(fc1);
    assign din[2] = 8'(din2);  assign ff[2] = 8'(ff2);  assign fc[2] = 9'(fc2);
    assign din[3] = din3;      assign ff[3] = ff3;      assign fc[3] = fc3;

    // Model gate under test: a truth table per instance.
    assign dout[0] = tt[0][din[0]];
    assign dout[1] = tt[1][din[1]];
    assign dout[2] = tt[2][din[2]];
    assign dout[3] = tt[3][din[3]];

    gate_sweep_tester #(.WIDTH(2), .MODE(0), .SETTLE_CYCLES(4), .AUTO_START(1), .BLINK_DIV(2)) u_or (
        .clk(clk), .rst_n(rstn[0]), .start(start[0]), .dut_in(din0), .dut_out(dout[0]),
        .busy(busy[0]), .done(done[0]), .fail_count(fc0), .first_fail(ff0),
        .led_pass(lpass[0]), .led_fail(lfail[0]), .led_busy(lbusy[0]));

    gate_sweep_tester #(.WIDTH(3), .MODE(2), .SETTLE_CYCLES(4), .AUTO_START(1), .BLINK_DIV(1)) u_xor (
        .clk(clk), .rst_n(rstn[1]), .start(start[1]), .dut_in(din1), .dut_out(dout[1]),
        .busy(busy[1]), .done(done[1]), .fail_count(fc1), .first_fail(ff1),
        .led_pass(lpass[1]), .led_fail(lfail[1]), .led_busy(lbusy[1]));

    gate_sweep_tester #(.WIDTH(4), .MODE(3), .SETTLE_CYCLES(2), .AUTO_START(0), .BLINK_DIV(2)) u_nor (
        .clk(clk), .rst_n(rstn[2]), .start(start[2]), .dut_in(din2), .dut_out(dout[2]),
        .busy(busy[2]), .done(done[2]), .fail_count(fc2), .first_fail(ff2),
        .led_pass(lpass[2]), .led_fail(lfail[2]), .led_busy(lbusy[2]));

    gate_sweep_tester #(.WIDTH(8), .MODE(4), .SETTLE_CYCLES(1), .AUTO_START(1), .BLINK_DIV(3)) u_nand (
        .clk(clk), .rst_n(rstn[3]), .start(start[3]), .dut_in(din3), .dut_out(dout[3]),
        .busy(busy[3]), .done(done[3]), .fail_count(fc3), .first_fail(ff3),
        .led_pass(lpass[3]), .led_fail(lfail[3]), .led_busy(lbusy[3]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic logic ref_gate(input int mode, input int w, input int v);
        int ones;
        ones = $countones(v);
        case (mode)
            0:       return ones > 0;
            1:       return ones == w;
            2:       return (ones % 2) == 1;
            3:       return ones == 0;
            4:       return ones != w;
            default: return (ones % 2) == 0;
        endcase
    endfunction

    // Truth table = golden gate with each entry flipped with probability pct%.
    task automatic mk_table(input int id, input int mode, input int w, input int pct);
        for (int v = 0; v < 256; v++)
            tt[id][v] = (v < (1 << w)) ? (ref_gate(mode, w, v) ^ ($urandom_range(0, 99) < pct)) : 1'b0;
    endtask

    task automatic wait_busy(input int id, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (busy[id]) ok = 1'b1;
        end
    endtask

    // Follows one sweep cycle by cycle from its first DRIVE to DONE.
    task automatic sweep(input int id, input int w, input int mode, input int s, input int bd,
                         input string tag);
        int len, nf, f1, firstc, errs, per, v;
        bit ok;
        len = (1 << w) * (s + 2);
        per = s + 2;
        nf  = 0;
        f1  = -1;
        for (int k = 0; k < (1 << w); k++) begin
            if (tt[id][k] != ref_gate(mode, w, k)) begin
                nf++;
                if (f1 < 0) f1 = k;
            end
        end
        firstc = (f1 < 0) ? 32'h7fff_ffff : f1 * per + s + 2;
        wait_busy(id, ok);
        chk({tag, " start"}, ok, 1);
        if (!ok) return;
        errs = 0;
        for (int c = 0; c < len; c++) begin
            v = c / per;
            if (!busy[id] || done[id] || lpass[id]) errs++;
            if ((c % per) != 0 && din[id] != v) errs++;
            if (c > 0 && (c % per) == 0 && din[id] != v - 1) errs++;
            if (lfail[id] != (c >= firstc)) errs++;
            if (lbusy[id] != ((c >> bd) & 1)) errs++;
            @(negedge clk);
        end
        chk({tag, " cycle_errs"}, errs, 0);
        chk({tag, " done"}, {done[id], busy[id], lbusy[id]}, 3'b100);
        chk({tag, " fail_count"}, fc[id], nf);
        chk({tag, " first_fail"}, ff[id], (f1 < 0) ? 0 : f1);
        chk({tag, " led_pass"}, lpass[id], nf == 0);
        chk({tag, " led_fail"}, lfail[id], nf != 0);
    endtask

    initial begin
        bit ok;
        int nexp;
        rstn  = '0;
        start = '0;
        tt    = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++)
            chk($sformatf("reset%0d", i),
                {busy[i], done[i], lpass[i], lfail[i], lbusy[i], fc[i], ff[i], din[i]}, 0);

        // OR, auto-start: correct gate, stuck-at-0 gate, then random faults
        mk_table(0, 0, 2, 0);
        rstn[0] = 1'b1;
        sweep(0, 2, 0, 4, 2, "or_ok");
        tt[0] = '0;
        sweep(0, 2, 0, 4, 2, "or_stuck0");
        chk("or_stuck0 fc", fc[0], 3);
        chk("or_stuck0 ff", ff[0], 1);
        repeat (4) begin
            mk_table(0, 0, 2, 35);
            sweep(0, 2, 0, 4, 2, "or_rand");
        end

        // reset pulsed during SETTLE of vector 2
        tt[0] = '0;
        wait_busy(0, ok);
        chk("rst_mid start", ok, 1);
        repeat (14) @(negedge clk);
        chk("rst_mid pre", {busy[0], lfail[0], fc[0]}, {1'b1, 1'b1, 9'd1});
        rstn[0] = 1'b0;
        @(negedge clk);
        chk("rst_mid zero", {busy[0], done[0], lpass[0], lfail[0], lbusy[0], fc[0], ff[0], din[0]}, 0);
        rstn[0] = 1'b1;
        mk_table(0, 0, 2, 0);
        sweep(0, 2, 0, 4, 2, "or_after_rst");
        rstn[0] = 1'b0;

        // XOR expected, AND gate fitted
        for (int v = 0; v < 256; v++) tt[1][v] = (v < 8) ? ref_gate(1, 3, v) : 1'b0;
        rstn[1] = 1'b1;
        sweep(1, 3, 2, 4, 1, "xor_and");
        chk("xor_and fc", fc[1], 3);
        chk("xor_and ff", ff[1], 1);
        repeat (4) begin
            mk_table(1, 2, 3, 25);
            sweep(1, 3, 2, 4, 1, "xor_rand");
        end
        rstn[1] = 1'b0;

        // NOR, manual start: hold in DONE, drop start, restart
        rstn[2] = 1'b1;
        repeat (4) @(negedge clk);
        chk("nor idle", {busy[2], done[2]}, 0);
        mk_table(2, 3, 4, 40);
        tt[2][5] = ~ref_gate(3, 4, 5);
        nexp = 0;
        for (int v = 0; v < 16; v++) nexp += (tt[2][v] != ref_gate(3, 4, v));
        start[2] = 1'b1;
        sweep(2, 4, 3, 2, 2, "nor_first");
        repeat (10) @(negedge clk);
        chk("nor hold", {done[2], busy[2], lfail[2], fc[2]}, {1'b1, 1'b0, 1'b1, 9'(nexp)});
        start[2] = 1'b0;
        @(negedge clk);
        chk("nor to_idle", {done[2], busy[2], lpass[2]}, 0);
        repeat (3) @(negedge clk);
        chk("nor stay_idle", {done[2], busy[2]}, 0);
        mk_table(2, 3, 4, 0);
        start[2] = 1'b1;
        sweep(2, 4, 3, 2, 2, "nor_second");
        start[2] = 1'b0;
        rstn[2]  = 1'b0;

        // NAND, 8 inputs, single settle cycle
        mk_table(3, 4, 8, 0);
        rstn[3] = 1'b1;
        sweep(3, 8, 4, 1, 3, "nand_ok");
        mk_table(3, 4, 8, 5);
        sweep(3, 8, 4, 1, 3, "nand_rand");
        rstn[3] = 1'b0;

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
